// File: rtl/cal_abs_pipe_if.sv
// ---------------------------------------------------------------------------
// cal_abs_pipe_if
//   Sample/result bundle for the complex-magnitude pipeline.
//   Parameters:
//     DW     : input component width
//     USER_W : sideband tag width
//     OW     : result width, DW+1 (derived)
//   Signals:
//     val_i  : input sample valid
//     real_i : real component
//     imag_i : imaginary component
//     user_i : sideband tag, sampled with val_i
//     abs_o  : magnitude result, unsigned
//     val_o  : abs_o/user_o valid
//     user_o : tag of the sample producing abs_o
//   Modports:
//     master : sample producer / result consumer
//     slave  : the magnitude unit
// ---------------------------------------------------------------------------
interface cal_abs_pipe_if #(
  parameter int DW     = 8,
  parameter int USER_W = 4
);
  localparam int OW = DW + 1;

  logic              val_i;
  logic [DW-1:0]     real_i;
  logic [DW-1:0]     imag_i;
  logic [USER_W-1:0] user_i;
  logic [OW-1:0]     abs_o;
  logic              val_o;
  logic [USER_W-1:0] user_o;

  modport master (
    output val_i, real_i, imag_i, user_i,
    input  abs_o, val_o, user_o
  );

  modport slave (
    input  val_i, real_i, imag_i, user_i,
    output abs_o, val_o, user_o
  );
endinterface

// File: rtl/cal_abs_pipe.sv
// ---------------------------------------------------------------------------
// cal_abs_pipe
//   Fully pipelined complex magnitude: abs_o = floor(sqrt(real^2 + imag^2)),
//   one sample per clock, no backpressure, fixed latency LAT = OW+3 cycles.
//   Pipeline: input register (optional two's complement |x|), squares, exact
//   sum, then one restoring square-root stage per result bit (MSB first),
//   then the output register.  Stage data registers only load when the
//   incoming stage valid is set, so idle cycles do not toggle the datapath
//   and X on the components during val_i=0 never reaches abs_o.
//
//   Optional build macro CAL_ABS_ROUND_EN: round to nearest at the output
//   register (q+1 when the final remainder exceeds q); latency unchanged.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset, clears every register
//     bus   : cal_abs_pipe_if.slave (val_i/real_i/imag_i/user_i in,
//             abs_o/val_o/user_o out, all outputs registered)
// ---------------------------------------------------------------------------
module cal_abs_pipe #(
  parameter int DW        = 8,
  parameter int SIGNED_IN = 0,
  parameter int USER_W    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cal_abs_pipe_if.slave bus
);
  localparam int OW  = DW + 1;
  localparam int LAT = OW + 3;
  localparam int NSQ = LAT - 3;     // square-root stages, one per result bit
  localparam int SW  = 2 * DW + 1;  // exact sum width
  localparam int PW  = 2 * OW;      // sum padded to whole bit pairs
  localparam int RW  = OW + 2;      // stored remainder width
  localparam int EW  = RW + 2;      // remainder after bringing down a pair

  // Unsigned magnitude of one component; -2^(DW-1) maps to 2^(DW-1).
  function automatic logic [DW-1:0] mag_f(input logic [DW-1:0] x);
    logic [DW-1:0] m;
    if ((SIGNED_IN != 32'sd0) && x[DW-1]) begin
      m = (~x) + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      m = x;
    end
    return m;
  endfunction

  // Next root bit: 1 when (4r + pair) >= (4q + 1).
  function automatic logic root_bit(input logic [OW-1:0] q,
                                    input logic [RW-1:0] r,
                                    input logic [1:0]    pair);
    logic [EW-1:0] rem_v;
    logic [EW-1:0] trial_v;
    rem_v   = {r, pair};
    trial_v = {2'b00, q, 2'b01};
    return (rem_v >= trial_v);
  endfunction

  // Next remainder of the restoring step (trial subtracted only if it fits).
  function automatic logic [RW-1:0] rem_next(input logic [OW-1:0] q,
                                             input logic [RW-1:0] r,
                                             input logic [1:0]    pair);
    logic [EW-1:0] rem_v;
    logic [EW-1:0] trial_v;
    logic [RW-1:0] res;
    rem_v   = {r, pair};
    trial_v = {2'b00, q, 2'b01};
    if (rem_v >= trial_v) begin
      res = RW'(rem_v - trial_v);
    end else begin
      res = rem_v[RW-1:0];
    end
    return res;
  endfunction

  // ---------------- stage 0: input capture / magnitude ----------------
  logic              v0_r;
  logic [DW-1:0]     re0_r;
  logic [DW-1:0]     im0_r;
  logic [USER_W-1:0] u0_r;

  // Capture accepted samples; component magnitudes taken here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r  <= 1'b0;
      re0_r <= {DW{1'b0}};
      im0_r <= {DW{1'b0}};
      u0_r  <= {USER_W{1'b0}};
    end else begin
      v0_r <= bus.val_i;
      if (bus.val_i) begin
        re0_r <= mag_f(bus.real_i);
        im0_r <= mag_f(bus.imag_i);
        u0_r  <= bus.user_i;
      end
    end
  end

  // ---------------- stage 1: squares ----------------
  logic                v1_r;
  logic [2*DW-1:0]     sq_re_r;
  logic [2*DW-1:0]     sq_im_r;
  logic [USER_W-1:0]   u1_r;

  // Square each magnitude at full 2*DW precision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      sq_re_r <= {(2*DW){1'b0}};
      sq_im_r <= {(2*DW){1'b0}};
      u1_r    <= {USER_W{1'b0}};
    end else begin
      v1_r <= v0_r;
      if (v0_r) begin
        sq_re_r <= (2*DW)'(re0_r) * (2*DW)'(re0_r);
        sq_im_r <= (2*DW)'(im0_r) * (2*DW)'(im0_r);
        u1_r    <= u0_r;
      end
    end
  end

  // ---------------- stage 2: exact sum ----------------
  logic              v2_r;
  logic [SW-1:0]     s_r;
  logic [USER_W-1:0] u2_r;

  // Sum of squares with one guard bit, never truncated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r <= 1'b0;
      s_r  <= {SW{1'b0}};
      u2_r <= {USER_W{1'b0}};
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        s_r  <= {1'b0, sq_re_r} + {1'b0, sq_im_r};
        u2_r <= u1_r;
      end
    end
  end

  // ---------------- square-root stages 0..NSQ-2 ----------------
  // Each stage consumes the top bit pair of the not-yet-used sum bits, so the
  // carried sum shrinks by two bits per stage.
  for (genvar j = 0; j < NSQ - 1; j++) begin : g_sq
    localparam int IW  = PW - 2 * j;  // sum bits still to be consumed
    localparam int SRW = IW - 2;      // sum bits passed on

    logic [OW-1:0]     q_in_s;
    logic [RW-1:0]     r_in_s;
    logic [IW-1:0]     sr_in_s;
    logic [USER_W-1:0] u_in_s;
    logic              v_in_s;

    logic [OW-1:0]     q_r;
    logic [RW-1:0]     r_r;
    logic [SRW-1:0]    sr_r;
    logic [USER_W-1:0] u_r;
    logic              v_r;

    if (j == 0) begin : g_head
      assign q_in_s  = {OW{1'b0}};
      assign r_in_s  = {RW{1'b0}};
      assign sr_in_s = {1'b0, s_r};
      assign u_in_s  = u2_r;
      assign v_in_s  = v2_r;
    end else begin : g_link
      assign q_in_s  = g_sq[j-1].q_r;
      assign r_in_s  = g_sq[j-1].r_r;
      assign sr_in_s = g_sq[j-1].sr_r;
      assign u_in_s  = g_sq[j-1].u_r;
      assign v_in_s  = g_sq[j-1].v_r;
    end

    // One restoring square-root step per clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_r  <= {OW{1'b0}};
        r_r  <= {RW{1'b0}};
        sr_r <= {SRW{1'b0}};
        u_r  <= {USER_W{1'b0}};
        v_r  <= 1'b0;
      end else begin
        v_r <= v_in_s;
        if (v_in_s) begin
          q_r  <= {q_in_s[OW-2:0], root_bit(q_in_s, r_in_s, sr_in_s[IW-1 -: 2])};
          r_r  <= rem_next(q_in_s, r_in_s, sr_in_s[IW-1 -: 2]);
          sr_r <= sr_in_s[SRW-1:0];
          u_r  <= u_in_s;
        end
      end
    end
  end

  // ---------------- last square-root stage ----------------
  logic [OW-1:0]     qf_in_s;
  logic [RW-1:0]     rf_in_s;
  logic [1:0]        pf_in_s;
  logic [USER_W-1:0] uf_in_s;
  logic              vf_in_s;

  assign qf_in_s = g_sq[NSQ-2].q_r;
  assign rf_in_s = g_sq[NSQ-2].r_r;
  assign pf_in_s = g_sq[NSQ-2].sr_r;
  assign uf_in_s = g_sq[NSQ-2].u_r;
  assign vf_in_s = g_sq[NSQ-2].v_r;

  logic [OW-1:0]     q_last_r;
  logic [USER_W-1:0] u_last_r;
  logic              v_last_r;
`ifdef CAL_ABS_ROUND_EN
  logic [RW-1:0]     r_last_r;
`endif

  // Final root bit; the remainder is only kept when rounding is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_last_r <= {OW{1'b0}};
      u_last_r <= {USER_W{1'b0}};
      v_last_r <= 1'b0;
`ifdef CAL_ABS_ROUND_EN
      r_last_r <= {RW{1'b0}};
`endif
    end else begin
      v_last_r <= vf_in_s;
      if (vf_in_s) begin
        q_last_r <= {qf_in_s[OW-2:0], root_bit(qf_in_s, rf_in_s, pf_in_s)};
        u_last_r <= uf_in_s;
`ifdef CAL_ABS_ROUND_EN
        r_last_r <= rem_next(qf_in_s, rf_in_s, pf_in_s);
`endif
      end
    end
  end

  // ---------------- output register ----------------
  logic [OW-1:0] abs_nx_s;

  // Result selection: floor root, or root+1 when s > q^2 + q (round build).
  always_comb begin
    abs_nx_s = q_last_r;
`ifdef CAL_ABS_ROUND_EN
    if (r_last_r > {2'b00, q_last_r}) begin
      abs_nx_s = q_last_r + {{(OW-1){1'b0}}, 1'b1};
    end else begin
      abs_nx_s = q_last_r;
    end
`endif
  end

  logic [OW-1:0]     abs_r;
  logic [USER_W-1:0] user_r;
  logic              val_r;

  // Output register; result and tag hold their last values while val_o=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_r  <= {OW{1'b0}};
      user_r <= {USER_W{1'b0}};
      val_r  <= 1'b0;
    end else begin
      val_r <= v_last_r;
      if (v_last_r) begin
        abs_r  <= abs_nx_s;
        user_r <= u_last_r;
      end
    end
  end

  assign bus.abs_o  = abs_r;
  assign bus.user_o = user_r;
  assign bus.val_o  = val_r;
endmodule

// File: tb/tb_cal_abs_pipe.sv
// ---------------------------------------------------------------------------
// tb_cal_abs_pipe
//   Three instances: A = DW8 unsigned, B = DW8 signed, C = DW16 unsigned.
//   Drivers push expected results (from an integer floor-sqrt model) into a
//   per-instance queue; per-instance monitors pop on val_o and compare value,
//   tag and acceptance-to-output distance, and check hold values on idle
//   cycles.  Scenario tasks add their own directed checks.
// ---------------------------------------------------------------------------
module tb_cal_abs_pipe;
  localparam int LAT8  = 12;
  localparam int LAT16 = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] abs;
    logic [3:0]  user;
    int          acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  logic [16:0] last_a = 17'd0, last_b = 17'd0, last_c = 17'd0;
  logic [3:0]  lu_a = 4'd0, lu_b = 4'd0, lu_c = 4'd0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;

  cal_abs_pipe_if #(.DW(8),  .USER_W(4)) ba ();
  cal_abs_pipe_if #(.DW(8),  .USER_W(4)) bb ();
  cal_abs_pipe_if #(.DW(16), .USER_W(4)) bc ();

  cal_abs_pipe #(.DW(8),  .SIGNED_IN(0), .USER_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba.slave));
  cal_abs_pipe #(.DW(8),  .SIGNED_IN(1), .USER_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb.slave));
  cal_abs_pipe #(.DW(16), .SIGNED_IN(0), .USER_W(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bc.slave));

  // Golden model: binary-search floor sqrt, optional round to nearest.
  function automatic logic [16:0] model_abs(input longint s);
    longint lo, hi, mid;
    lo = 0;
    hi = 131071;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid - 1;
    end
`ifdef CAL_ABS_ROUND_EN
    if (s > lo * lo + lo) lo = lo + 1;
`endif
    return 17'(lo);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_a(input logic v, input logic [7:0] re, input logic [7:0] im, input logic [3:0] u);
    exp_t e;
    longint a, b;
    @(negedge clk);
    ba.val_i = v; ba.real_i = re; ba.imag_i = im; ba.user_i = u;
    if (v) begin
      a = longint'(re); b = longint'(im);
      e.abs = model_abs(a * a + b * b); e.user = u; e.acc = cyc + 1;
      qa.push_back(e);
    end
  endtask

  task automatic drive_b(input logic v, input logic [7:0] re, input logic [7:0] im, input logic [3:0] u);
    exp_t e;
    longint a, b;
    @(negedge clk);
    bb.val_i = v; bb.real_i = re; bb.imag_i = im; bb.user_i = u;
    if (v) begin
      a = longint'($signed(re)); b = longint'($signed(im));
      e.abs = model_abs(a * a + b * b); e.user = u; e.acc = cyc + 1;
      qb.push_back(e);
    end
  endtask

  task automatic drive_c(input logic v, input logic [15:0] re, input logic [15:0] im, input logic [3:0] u);
    exp_t e;
    longint a, b;
    @(negedge clk);
    bc.val_i = v; bc.real_i = re; bc.imag_i = im; bc.user_i = u;
    if (v) begin
      a = longint'(re); b = longint'(im);
      e.abs = model_abs(a * a + b * b); e.user = u; e.acc = cyc + 1;
      qc.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ba.val_i = 1'b0; bb.val_i = 1'b0; bc.val_i = 1'b0;
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n) begin
      if (ba.val_o) begin
        cnt_a++;
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_out: got abs=%0d at cycle %0d, required no output", ba.abs_o, cyc);
        end else begin
          e = qa.pop_front();
          if (ba.abs_o !== e.abs[8:0] || ba.user_o !== e.user || cyc - e.acc != LAT8) begin
            errors++;
            $display("FAIL a_result: got abs=%0d user=%0d lat=%0d, required abs=%0d user=%0d lat=%0d",
                     ba.abs_o, ba.user_o, cyc - e.acc, e.abs, e.user, LAT8);
          end
          last_a = e.abs; lu_a = e.user;
        end
      end else begin
        checks++;
        if (ba.abs_o !== last_a[8:0] || ba.user_o !== lu_a) begin
          errors++;
          $display("FAIL a_hold: got abs=%0d user=%0d, required abs=%0d user=%0d", ba.abs_o, ba.user_o, last_a, lu_a);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n) begin
      if (bb.val_o) begin
        cnt_b++;
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_out: got abs=%0d at cycle %0d, required no output", bb.abs_o, cyc);
        end else begin
          e = qb.pop_front();
          if (bb.abs_o !== e.abs[8:0] || bb.user_o !== e.user || cyc - e.acc != LAT8) begin
            errors++;
            $display("FAIL b_result: got abs=%0d user=%0d lat=%0d, required abs=%0d user=%0d lat=%0d",
                     bb.abs_o, bb.user_o, cyc - e.acc, e.abs, e.user, LAT8);
          end
          last_b = e.abs; lu_b = e.user;
        end
      end else begin
        checks++;
        if (bb.abs_o !== last_b[8:0] || bb.user_o !== lu_b) begin
          errors++;
          $display("FAIL b_hold: got abs=%0d user=%0d, required abs=%0d user=%0d", bb.abs_o, bb.user_o, last_b, lu_b);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (rst_n) begin
      if (bc.val_o) begin
        cnt_c++;
        checks++;
        if (qc.size() == 0) begin
          errors++;
          $display("FAIL c_unexpected_out: got abs=%0d at cycle %0d, required no output", bc.abs_o, cyc);
        end else begin
          e = qc.pop_front();
          if (bc.abs_o !== e.abs || bc.user_o !== e.user || cyc - e.acc != LAT16) begin
            errors++;
            $display("FAIL c_result: got abs=%0d user=%0d lat=%0d, required abs=%0d user=%0d lat=%0d",
                     bc.abs_o, bc.user_o, cyc - e.acc, e.abs, e.user, LAT16);
          end
          last_c = e.abs; lu_c = e.user;
        end
      end else begin
        checks++;
        if (bc.abs_o !== last_c || bc.user_o !== lu_c) begin
          errors++;
          $display("FAIL c_hold: got abs=%0d user=%0d, required abs=%0d user=%0d", bc.abs_o, bc.user_o, last_c, lu_c);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks += 3;
    if (ba.val_o !== 1'b0 || ba.abs_o !== 9'd0 || ba.user_o !== 4'd0) begin
      errors++; $display("FAIL reset_a: got val=%0d abs=%0d user=%0d, required 0 0 0", ba.val_o, ba.abs_o, ba.user_o);
    end
    if (bb.val_o !== 1'b0 || bb.abs_o !== 9'd0 || bb.user_o !== 4'd0) begin
      errors++; $display("FAIL reset_b: got val=%0d abs=%0d user=%0d, required 0 0 0", bb.val_o, bb.abs_o, bb.user_o);
    end
    if (bc.val_o !== 1'b0 || bc.abs_o !== 17'd0 || bc.user_o !== 4'd0) begin
      errors++; $display("FAIL reset_c: got val=%0d abs=%0d user=%0d, required 0 0 0", bc.val_o, bc.abs_o, bc.user_o);
    end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_single();
    int acc, hits, hcyc;
    logic [8:0] habs;
    logic [3:0] husr;
    hits = 0; hcyc = 0; habs = 9'd0; husr = 4'd0;
    drive_a(1'b1, 8'd3, 8'd4, 4'd5);
    acc = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ba.val_i = 1'b0;
      if (ba.val_o) begin
        hits++; hcyc = cyc; habs = ba.abs_o; husr = ba.user_o;
      end
    end
    checks += 2;
    if (hits != 1) begin
      errors++; $display("FAIL single_count: got %0d outputs, required 1", hits);
    end
    if (hcyc - acc != LAT8 || habs !== 9'd5 || husr !== 4'd5) begin
      errors++; $display("FAIL single_value: got lat=%0d abs=%0d user=%0d, required lat=12 abs=5 user=5", hcyc - acc, habs, husr);
    end
  endtask

  task automatic test_corners();
    logic [8:0] req [3];
    logic [8:0] got [3];
    int gcyc [3];
    int n;
    req[0] = 9'd0; req[1] = 9'd255;
`ifdef CAL_ABS_ROUND_EN
    req[2] = 9'd361;
`else
    req[2] = 9'd360;
`endif
    n = 0;
    drive_a(1'b1, 8'd0,   8'd0,   4'd1);
    drive_a(1'b1, 8'd255, 8'd0,   4'd2);
    drive_a(1'b1, 8'd255, 8'd255, 4'd3);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ba.val_i = 1'b0;
      if (ba.val_o && n < 3) begin
        got[n] = ba.abs_o; gcyc[n] = cyc; n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL corners_count: got %0d outputs, required 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== req[i]) begin
          errors++; $display("FAIL corners_value[%0d]: got %0d, required %0d", i, got[i], req[i]);
        end
      end
      checks++;
      if (gcyc[2] - gcyc[0] != 2) begin
        errors++; $display("FAIL corners_b2b: got span %0d, required 2", gcyc[2] - gcyc[0]);
      end
    end
  endtask

  task automatic test_signed();
    logic [8:0] got [3];
    logic [3:0] gu [3];
    logic [8:0] req [3];
    int n;
    req[0] = 9'd181; req[1] = 9'd5; req[2] = 9'd127;
    n = 0;
    drive_b(1'b1, 8'h80, 8'h80, 4'd1);
    drive_b(1'b1, 8'hFD, 8'h04, 4'd2);
    drive_b(1'b1, 8'h7F, 8'hFF, 4'd3);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bb.val_i = 1'b0;
      if (bb.val_o && n < 3) begin
        got[n] = bb.abs_o; gu[n] = bb.user_o; n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL signed_count: got %0d outputs, required 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== req[i] || gu[i] !== 4'(i + 1)) begin
          errors++; $display("FAIL signed_value[%0d]: got abs=%0d user=%0d, required abs=%0d user=%0d", i, got[i], gu[i], req[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_stream();
    int n0, sent;
    logic v;
    n0 = cnt_a;
    for (int i = 0; i < 1024; i++) begin
      drive_a(1'b1, 8'($urandom), 8'($urandom), 4'($urandom));
    end
    idle(20);
    checks++;
    if (cnt_a - n0 != 1024) begin
      errors++; $display("FAIL stream_full_count: got %0d, required 1024", cnt_a - n0);
    end
    n0 = cnt_a;
    sent = 0;
    while (sent < 1024) begin
      v = ($urandom_range(99) >= 30);
      if (v) begin
        drive_a(1'b1, 8'($urandom), 8'($urandom), 4'($urandom));
        sent++;
      end else begin
        drive_a(1'b0, 8'hxx, 8'hxx, 4'($urandom));
      end
    end
    idle(20);
    checks++;
    if (cnt_a - n0 != 1024) begin
      errors++; $display("FAIL stream_bubble_count: got %0d, required 1024", cnt_a - n0);
    end
  endtask

  task automatic test_reset_mid();
    int n0, acc, hits, hcyc;
    logic [8:0] habs;
    for (int i = 0; i < 20; i++) begin
      drive_a(1'b1, 8'($urandom_range(255, 16)), 8'($urandom_range(255, 16)), 4'($urandom_range(15, 1)));
    end
    #2;
    rst_n = 1'b0;
    ba.val_i = 1'b0;
    #1;
    checks++;
    if (ba.val_o !== 1'b0 || ba.abs_o !== 9'd0 || ba.user_o !== 4'd0) begin
      errors++; $display("FAIL midreset_async: got val=%0d abs=%0d user=%0d, required 0 0 0", ba.val_o, ba.abs_o, ba.user_o);
    end
    qa.delete(); qb.delete(); qc.delete();
    last_a = 17'd0; last_b = 17'd0; last_c = 17'd0;
    lu_a = 4'd0; lu_b = 4'd0; lu_c = 4'd0;
    idle(3);
    rst_n = 1'b1;
    n0 = cnt_a;
    idle(20);
    checks++;
    if (cnt_a != n0) begin
      errors++; $display("FAIL midreset_stale: got %0d outputs, required 0", cnt_a - n0);
    end
    hits = 0; hcyc = 0; habs = 9'd0;
    drive_a(1'b1, 8'd30, 8'd40, 4'd7);
    acc = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ba.val_i = 1'b0;
      if (ba.val_o) begin
        hits++; hcyc = cyc; habs = ba.abs_o;
      end
    end
    checks++;
    if (hits != 1 || hcyc - acc != LAT8 || habs !== 9'd50) begin
      errors++; $display("FAIL midreset_first: got hits=%0d lat=%0d abs=%0d, required 1 12 50", hits, hcyc - acc, habs);
    end
  endtask

  task automatic test_wide();
    int n0, acc, hits, hcyc;
    logic [16:0] habs;
    hits = 0; hcyc = 0; habs = 17'd0;
    drive_c(1'b1, 16'hFFFF, 16'hFFFF, 4'd9);
    acc = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bc.val_i = 1'b0;
      if (bc.val_o) begin
        hits++; hcyc = cyc; habs = bc.abs_o;
      end
    end
    checks++;
    if (hits != 1 || hcyc - acc != LAT16 || habs !== 17'd92680) begin
      errors++; $display("FAIL wide_max: got hits=%0d lat=%0d abs=%0d, required 1 20 92680", hits, hcyc - acc, habs);
    end
    n0 = cnt_c;
    drive_c(1'b1, 16'd0, 16'd0, 4'd1);
    drive_c(1'b1, 16'hFFFF, 16'd0, 4'd2);
    for (int i = 0; i < 500; i++) begin
      drive_c(1'b1, 16'($urandom), 16'($urandom), 4'($urandom));
    end
    idle(30);
    checks++;
    if (cnt_c - n0 != 502) begin
      errors++; $display("FAIL wide_count: got %0d, required 502", cnt_c - n0);
    end
  endtask

  initial begin
    ba.val_i = 1'b0; ba.real_i = 8'd0;  ba.imag_i = 8'd0;  ba.user_i = 4'd0;
    bb.val_i = 1'b0; bb.real_i = 8'd0;  bb.imag_i = 8'd0;  bb.user_i = 4'd0;
    bc.val_i = 1'b0; bc.real_i = 16'd0; bc.imag_i = 16'd0; bc.user_i = 4'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_corners();
    test_signed();
    test_stream();
    test_reset_mid();
    test_wide();
    idle(5);
    checks++;
    if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
      errors++; $display("FAIL drain: got pending %0d/%0d/%0d, required 0/0/0", qa.size(), qb.size(), qc.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
